// File: rtl/mul_wb.sv
// Sequential shift-add multiplier with a single register-file write-back beat.
// Optional build macro MUL_WB_SIGNED_EN selects two's complement operands.
module mul_wb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic                  sel_hi,
    output logic                  busy,
    output logic                  done,
    output logic                  w,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_t;

    state_t                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   dest_q, dest_d;
    logic                    sel_hi_q, sel_hi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    w_q, w_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    last_iter;
    logic [DATA_WIDTH:0]     hi_ext;
    logic [DATA_WIDTH:0]     addend;
    logic [DATA_WIDTH:0]     sum;
    logic [2*DATA_WIDTH-1:0] acc_step;

    // The multiplier lives in the lower accumulator half, so acc_q[0] is the
    // current multiplier bit and product bits shift in from the top.
    always_comb begin
        last_iter = (count_q == CNT_W'(1));
`ifdef MUL_WB_SIGNED_EN
        hi_ext    = {acc_q[2*DATA_WIDTH-1], acc_q[2*DATA_WIDTH-1:DATA_WIDTH]};
        addend    = acc_q[0] ? {mcand_q[DATA_WIDTH-1], mcand_q} : '0;
        sum       = last_iter ? (hi_ext - addend) : (hi_ext + addend);
`else
        hi_ext    = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]};
        addend    = acc_q[0] ? {1'b0, mcand_q} : '0;
        sum       = hi_ext + addend;
`endif
        acc_step  = {sum, acc_q[DATA_WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        dest_d   = dest_q;
        sel_hi_d = sel_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        w_d      = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_d    = {{DATA_WIDTH{1'b0}}, b};
                    count_d  = CNT_W'(DATA_WIDTH);
                    dest_d   = dest;
                    sel_hi_d = sel_hi;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_step;
                count_d = count_q - CNT_W'(1);
                if (last_iter) begin
                    w_d     = 1'b1;
                    done_d  = 1'b1;
                    waddr_d = dest_q;
                    wdata_d = sel_hi_q ? acc_step[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : acc_step[DATA_WIDTH-1:0];
                    state_d = WB;
                end
            end
            WB: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            count_q  <= '0;
            dest_q   <= '0;
            sel_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            w_q      <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            count_q  <= count_d;
            dest_q   <= dest_d;
            sel_hi_q <= sel_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            w_q      <= w_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign w     = w_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_mul_wb.sv
// Self-checking bench for mul_wb: cycle-level timing model plus directed vectors.
module tb_mul_wb;

    localparam int W  = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          sel_hi = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [AW-1:0] dest = '0;
    logic          busy, done, w;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_writes = 0;

    mul_wb #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .dest    (dest),
        .sel_hi  (sel_hi),
        .busy    (busy),
        .done    (done),
        .w       (w),
        .waddr   (waddr),
        .wdata   (wdata)
    );

    always #5 clk = ~clk;

    // Model: product by plain multiplication, timing by a countdown of cycles.
    int            m_phase = 0;
    logic          m_busy = 1'b0;
    logic          m_w = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [AW-1:0] m_dest = '0;
    logic [W-1:0]  m_wdata = '0;
    logic [W-1:0]  m_val = '0;

    function automatic logic [W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic hi);
        logic [2*W-1:0] p;
`ifdef MUL_WB_SIGNED_EN
        p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
`else
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
        return hi ? p[2*W-1:W] : p[W-1:0];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_busy  <= 1'b0;
            m_w     <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
        end else if (m_phase == 0) begin
            m_w <= 1'b0;
            if (start) begin
                m_phase <= W + 1;
                m_busy  <= 1'b1;
                m_dest  <= dest;
                m_val   <= model_prod(a, b, sel_hi);
            end
        end else begin
            m_phase <= m_phase - 1;
            m_w     <= (m_phase == 2);
            if (m_phase == 2) begin
                m_waddr <= m_dest;
                m_wdata <= m_val;
            end
            if (m_phase == 1) m_busy <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle boundary goes through here: outputs compared to the model.
    task automatic tick();
        @(negedge clk);
        chk("busy_vs_model", {31'd0, busy}, {31'd0, m_busy});
        chk("w_vs_model", {31'd0, w}, {31'd0, m_w});
        chk("done_vs_model", {31'd0, done}, {31'd0, m_w});
        chk("waddr_vs_model", 32'(waddr), 32'(m_waddr));
        chk("wdata_vs_model", 32'(wdata), 32'(m_wdata));
        if (w === 1'b1) n_writes++;
    endtask

    task automatic wait_write(output int lat);
        lat = 0;
        while (w !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("write_seen", {31'd0, w}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [AW-1:0] xd, input logic hi,
                         input logic [AW-1:0] exp_addr, input logic [W-1:0] exp_data);
        int lat;
        a = xa; b = xb; dest = xd; sel_hi = hi; start = 1'b1;
        tick();
        start = 1'b0;
        wait_write(lat);
        chk({name, "_latency"}, 32'(lat), 32'(W));
        chk({name, "_waddr"}, 32'(waddr), 32'(exp_addr));
        chk({name, "_wdata"}, 32'(wdata), 32'(exp_data));
        chk({name, "_model"}, 32'(m_wdata), 32'(exp_data));
        tick();
        chk({name, "_w_pulse"}, {31'd0, w}, 32'd0);
        chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int wr_before;

        // Reset then idle
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_w", {31'd0, w}, 32'd0);
        chk("idle_wdata", 32'(wdata), 32'd0);
        chk("idle_waddr", 32'(waddr), 32'd0);

        // Basic
        do_op("basic_lo", 8'd13, 8'd11, 2'd2, 1'b0, 2'd2, 8'h8F);
        do_op("basic_hi", 8'd13, 8'd11, 2'd2, 1'b1, 2'd2, 8'h00);

        // Max operands
`ifdef MUL_WB_SIGNED_EN
        do_op("max_hi", 8'hFF, 8'hFF, 2'd3, 1'b1, 2'd3, 8'h00);
        do_op("max_lo", 8'hFF, 8'hFF, 2'd3, 1'b0, 2'd3, 8'h01);
        do_op("neg_hi", 8'h80, 8'h02, 2'd3, 1'b1, 2'd3, 8'hFF);
        do_op("neg_lo", 8'h80, 8'h02, 2'd3, 1'b0, 2'd3, 8'h00);
`else
        do_op("max_hi", 8'hFF, 8'hFF, 2'd3, 1'b1, 2'd3, 8'hFE);
        do_op("max_lo", 8'hFF, 8'hFF, 2'd3, 1'b0, 2'd3, 8'h01);
`endif

        // Start while busy, then start on the WB exit edge, then one cycle later
        wr_before = n_writes;
        a = 8'd5; b = 8'd6; dest = 2'd1; sel_hi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'd9; b = 8'd9; dest = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (w !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("busy_start_write_seen", {31'd0, w}, 32'd1);
        chk("busy_start_latency", 32'(lat), 32'(W));
        chk("busy_start_waddr", 32'(waddr), 32'd1);
        chk("busy_start_wdata", 32'(wdata), 32'h1E);
        start = 1'b1;
        tick();
        chk("wb_exit_busy", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        chk("wb_exit_ignored_busy", {31'd0, busy}, 32'd1);
        chk("busy_start_single_write", 32'(n_writes - wr_before), 32'd1);
        wait_write(lat);
        chk("b2b_latency", 32'(lat), 32'(W));
        chk("b2b_waddr", 32'(waddr), 32'd0);
        chk("b2b_wdata", 32'(wdata), 32'h51);
        tick();
        chk("b2b_total_writes", 32'(n_writes - wr_before), 32'd2);

        // Reset mid-operation
        wr_before = n_writes;
        a = 8'd7; b = 8'd7; dest = 2'd1; sel_hi = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_w", {31'd0, w}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_write", 32'(n_writes - wr_before), 32'd0);
        do_op("after_abort", 8'd2, 8'd3, 2'd2, 1'b0, 2'd2, 8'h06);

        // Zero operand: fixed latency, one-cycle done
        do_op("zero", 8'h00, 8'hAB, 2'd1, 1'b0, 2'd1, 8'h00);
        for (int i = 0; i < 3; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
